// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add 32x32 -> 64 multiplier (mult/multu) that borrows the
// datapath's external carry-less ripple adder one step per cycle.
module shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   acc_hi_r, acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_r, acc_lo_s;
    logic [WIDTH-1:0]   mcand_r, mcand_s;
    logic               neg_r, neg_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic               carry_s;
    logic [2*WIDTH-1:0] product_s;

    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Adder operands: partial product add during CALC, quiet otherwise.
    always_comb begin
        add_a = {WIDTH{1'b0}};
        add_b = {WIDTH{1'b0}};
        case (state_r)
            CALC: begin
                add_a = acc_hi_r;
                add_b = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};
            end
            default: begin
                add_a = {WIDTH{1'b0}};
                add_b = {WIDTH{1'b0}};
            end
        endcase
    end

    // The adder drops its carry-out; recover it from the operand and sum MSBs.
    assign carry_s = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                     ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

    // Next-state and datapath update.
    always_comb begin
        state_s   = state_r;
        acc_hi_s  = acc_hi_r;
        acc_lo_s  = acc_lo_r;
        mcand_s   = mcand_r;
        neg_s     = neg_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        hi_s      = hi_r;
        lo_s      = lo_r;
        product_s = {acc_hi_r, acc_lo_r};
        case (state_r)
            IDLE: begin
                if (start) begin
                    mcand_s  = magnitude(op_a, is_signed);
                    acc_lo_s = magnitude(op_b, is_signed);
                    acc_hi_s = {WIDTH{1'b0}};
                    neg_s    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = CALC;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            CALC: begin
                acc_hi_s = {carry_s, add_sum[WIDTH-1:1]};
                acc_lo_s = {add_sum[0], acc_lo_r[WIDTH-1:1]};
                cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (neg_r) begin
                    product_s = negate2w({acc_hi_r, acc_lo_r});
                end else begin
                    product_s = {acc_hi_r, acc_lo_r};
                end
                acc_hi_s = product_s[2*WIDTH-1:WIDTH];
                acc_lo_s = product_s[WIDTH-1:0];
                hi_s     = product_s[2*WIDTH-1:WIDTH];
                lo_s     = product_s[WIDTH-1:0];
                done_s   = 1'b1;
                busy_s   = 1'b0;
                state_s  = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset cancels any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            mcand_r  <= mcand_s;
            neg_r    <= neg_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
        end
    end

endmodule
